// File: rtl/seq_fifo_pkg.sv
// Shared sizes and types for the register-file-backed queue controller.
// Imported by the pointer sub-module and the controller top.
package seq_fifo_pkg;
  localparam int NENTRIES = 8;
  localparam int NBITS    = 8;
  localparam int ADDR_W   = 3;
  localparam int CNT_W    = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/seq_ptr_wrap.sv
// Wrapping queue pointer: register, increment enable, natural wrap.
// Ports: clk, reset_n (async, low), inc, ptr.
module seq_ptr_wrap
  import seq_fifo_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  inc,
  output addr_t ptr
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + addr_t'(1);
    end
  end

endmodule

// File: rtl/seq_fifo_8x8b_rf_ctrl.sv
// Queue controller over an external 1R/1W register file with forwarding.
// Ports: enq/deq val-rdy streams, rf read/write ports, count, flags.
module seq_fifo_8x8b_rf_ctrl
  import seq_fifo_pkg::*;
#(
  parameter int NBITS        = seq_fifo_pkg::NBITS,
  parameter int NENTRIES     = seq_fifo_pkg::NENTRIES,
  parameter int AFULL_THRESH = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enq_val,
  output logic              enq_rdy,
  input  logic [NBITS-1:0]  enq_msg,
  output logic              deq_val,
  input  logic              deq_rdy,
  output logic [NBITS-1:0]  deq_msg,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [NBITS-1:0]  rf_read_data,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [NBITS-1:0]  rf_write_data,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full,
  output logic              err_ovf,
  output logic              err_unf
);

  logic  enq_fire;
  logic  deq_fire;
  cnt_t  count_nxt;
  addr_t head;
  addr_t tail;

  // enq_rdy looks only at count, never at deq_rdy
  assign enq_rdy  = (count != cnt_t'(NENTRIES));
  assign deq_val  = (count != '0);
  assign enq_fire = enq_val & enq_rdy;
  assign deq_fire = deq_val & deq_rdy;

  assign deq_msg       = rf_read_data;
  assign rf_read_addr  = head;
  assign rf_write_addr = tail;
  assign rf_write_en   = enq_fire;
  assign rf_write_data = enq_msg;

  seq_ptr_wrap u_head (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (deq_fire),
    .ptr     (head)
  );

  seq_ptr_wrap u_tail (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (enq_fire),
    .ptr     (tail)
  );

  always_comb begin
    count_nxt = count + cnt_t'(enq_fire) - cnt_t'(deq_fire);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      almost_full <= 1'b0;
      err_ovf     <= 1'b0;
      err_unf     <= 1'b0;
    end else begin
      count       <= count_nxt;
      // registered from next count so it moves with count
      almost_full <= (count_nxt >= cnt_t'(AFULL_THRESH));
      err_ovf     <= err_ovf | (enq_val & ~enq_rdy);
      err_unf     <= err_unf | (deq_rdy & ~deq_val);
    end
  end

endmodule

// File: tb/tb_seq_fifo_8x8b_rf_ctrl.sv
// Bench for the queue controller with a forwarding register-file model.
// Scoreboard queue of accepted payloads, popped by a dequeue monitor.
module tb_seq_fifo_8x8b_rf_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enq_val;
  logic       enq_rdy;
  logic [7:0] enq_msg;
  logic       deq_val;
  logic       deq_rdy;
  logic [7:0] deq_msg;
  logic [2:0] rf_read_addr;
  logic [7:0] rf_read_data;
  logic       rf_write_en;
  logic [2:0] rf_write_addr;
  logic [7:0] rf_write_data;
  logic [3:0] count;
  logic       almost_full;
  logic       err_ovf;
  logic       err_unf;

  int passes = 0;
  int total  = 0;

  logic [7:0] sb[$];
  logic [7:0] mem [8];

  always #5 clk = ~clk;

  seq_fifo_8x8b_rf_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enq_val       (enq_val),
    .enq_rdy       (enq_rdy),
    .enq_msg       (enq_msg),
    .deq_val       (deq_val),
    .deq_rdy       (deq_rdy),
    .deq_msg       (deq_msg),
    .rf_read_addr  (rf_read_addr),
    .rf_read_data  (rf_read_data),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .count         (count),
    .almost_full   (almost_full),
    .err_ovf       (err_ovf),
    .err_unf       (err_unf)
  );

  // register file with write-to-read forwarding
  always @(posedge clk) begin
    if (rf_write_en) mem[rf_write_addr] <= rf_write_data;
  end

  always_comb begin
    rf_read_data = mem[rf_read_addr];
    if (rf_write_en && rf_write_addr == rf_read_addr)
      rf_read_data = rf_write_data;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor: compare dequeues, then record accepted enqueues
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (deq_val && deq_rdy) begin
        if (sb.size() == 0) chk("deq_unexpected", 1, 0);
        else chk("deq_msg", {24'h0, deq_msg}, {24'h0, sb.pop_front()});
      end
      if (enq_val && enq_rdy) sb.push_back(enq_msg);
    end
  end

  task automatic drive(input logic ev, input logic [7:0] m,
                       input logic dr);
    @(posedge clk);
    #1;
    enq_val = ev;
    enq_msg = m;
    deq_rdy = dr;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    enq_val = 1'b0;
    enq_msg = 8'h00;
    deq_rdy = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_enq_rdy", enq_rdy, 1);
    chk("rst_deq_val", deq_val, 0);
    chk("rst_count", count, 0);
    chk("rst_wen", rf_write_en, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_ovf", err_ovf, 0);
    chk("rst_unf", err_unf, 0);

    // fill
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
      chk("fill_waddr", rf_write_addr, i);
      chk("fill_wen", rf_write_en, 1);
      chk("fill_count", count, i);
      chk("fill_afull", almost_full, (i >= 6) ? 1 : 0);
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("full_count", count, 8);
    chk("full_enq_rdy", enq_rdy, 0);
    chk("full_afull", almost_full, 1);
    chk("full_deq_val", deq_val, 1);

    // full with both sides requesting
    drive(1'b1, 8'h99, 1'b1);
    chk("full_both_wen", rf_write_en, 0);
    chk("full_both_msg", deq_msg, 8'h11);
    chk("full_both_ovf", err_ovf, 0);
    drive(1'b0, 8'h00, 1'b0);
    chk("after_full_count", count, 7);
    chk("after_full_ovf", err_ovf, 1);
    chk("after_full_unf", err_unf, 0);
    chk("after_full_afull", almost_full, 1);

    // drain to two entries
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("pre_stream_count", count, 2);
    chk("pre_stream_afull", almost_full, 0);

    // steady stream: head starts at 6, tail at 0
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(8'hC0 + i), 1'b1);
      chk("stream_count", count, 2);
      chk("stream_raddr", rf_read_addr, (6 + i) % 8);
      chk("stream_waddr", rf_write_addr, i % 8);
    end
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("drained_count", count, 0);
    chk("drained_unf", err_unf, 0);

    // empty with simultaneous enqueue and deq_rdy
    drive(1'b1, 8'hA5, 1'b1);
    chk("empty_deq_val", deq_val, 0);
    chk("empty_wen", rf_write_en, 1);
    drive(1'b0, 8'h00, 1'b1);
    chk("bypass_deq_val", deq_val, 1);
    chk("bypass_msg", deq_msg, 8'hA5);
    chk("bypass_count", count, 1);
    chk("bypass_unf", err_unf, 1);
    drive(1'b0, 8'h00, 1'b0);
    chk("bypass_done_count", count, 0);

    // async reset mid-stream
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h30 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("pre_rst_count", count, 5);
    #2 reset_n = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_deq_val", deq_val, 0);
    chk("async_enq_rdy", enq_rdy, 1);
    chk("async_ovf", err_ovf, 0);
    chk("async_unf", err_unf, 0);
    sb.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    drive(1'b1, 8'h5A, 1'b0);
    chk("post_rst_waddr", rf_write_addr, 0);
    drive(1'b0, 8'h00, 1'b1);
    chk("post_rst_raddr", rf_read_addr, 0);
    drive(1'b0, 8'h00, 1'b0);
    chk("final_count", count, 0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/seq_fifo_8x8b_rf_ctrl.md
Name: seq_fifo_8x8b_rf_ctrl

Overview:
- Queue controller that sits directly upstream of the 8-entry, 8-bit, 1-read/1-write register file with write-to-read forwarding.
- Turns a val/rdy enqueue stream into register-file writes.
- Presents the register-file read data as a val/rdy dequeue stream.
- Keeps head/tail pointers, occupancy, an almost-full flag and sticky protocol-error flags. Storage lives in the external register file only.

Parameters:
- NBITS, 8, payload width; must match the register-file data width.
- NENTRIES, 8, queue depth; must match the register-file entry count and be a power of two.
- AFULL_THRESH, 6, occupancy at or above which almost_full asserts.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enq_val  input  1  producer has a message.
- enq_rdy  output  1  controller can accept a message.
- enq_msg  input  NBITS  enqueue payload.
- deq_val  output  1  head message is valid.
- deq_rdy  input  1  consumer accepts the head.
- deq_msg  output  NBITS  head payload.
- rf_read_addr  output  3  register-file read address, equal to the head pointer.
- rf_read_data  input  NBITS  register-file read data.
- rf_write_en  output  1  register-file write enable.
- rf_write_addr  output  3  register-file write address, equal to the tail pointer.
- rf_write_data  output  NBITS  register-file write data, equal to enq_msg.
- count  output  4  occupancy, 0..8.
- almost_full  output  1  count >= AFULL_THRESH.
- err_ovf  output  1  sticky: enq_val seen while enq_rdy=0.
- err_unf  output  1  sticky: deq_rdy seen while deq_val=0 (diagnostic only).

Behaviour:
- Reset (reset_n=0, acts asynchronously):
  - head=0, tail=0, count=0, err_ovf=0, err_unf=0.
  - Resulting outputs: enq_rdy=1, deq_val=0, rf_write_en=0, almost_full=0.
  - Reset mid-operation discards all queued data. Register-file contents are not cleared, and are never observed because count=0.
- Handshake rules:
  - enq_fire = enq_val & enq_rdy.
  - deq_fire = deq_val & deq_rdy.
- Combinational outputs:
  - enq_rdy = (count != NENTRIES). It does not depend on deq_rdy, so no combinational path runs from deq_rdy to enq_rdy.
  - deq_val = (count != 0).
  - deq_msg = rf_read_data.
  - rf_read_addr = head.
  - rf_write_addr = tail.
  - rf_write_en = enq_fire.
  - rf_write_data = enq_msg.
- Sequential updates, each on the rising clk edge:
  - tail increments by 1 mod NENTRIES when enq_fire.
  - head increments by 1 mod NENTRIES when deq_fire.
  - count += enq_fire - deq_fire.
  - Wrap-around from 7 to 0 is natural 3-bit overflow.
- Latency:
  - A message enqueued in cycle t is dequeueable from cycle t+1 (deq_val=1).
  - No same-cycle bypass: when empty, the register file's forwarding presents enq_msg on rf_read_data, but deq_val=0, so the consumer ignores it.
- Boundary cases:
  - Full (count=8): enq_rdy=0, even if deq_rdy=1 in the same cycle. A dequeue that cycle yields count=7.
  - Empty plus simultaneous enq_val and deq_rdy: only the enqueue fires; count becomes 1.
  - count between 1 and 7 with enqueue and dequeue both firing: count unchanged, head and tail both advance.
  - Simultaneous fire with head==tail cannot occur, because head==tail implies count of 0 or 8.
  - count is 4 bits so that 8 is distinguishable from 0.
- Flags:
  - almost_full is registered from the next-count value and changes in the same edge as count.
  - err_ovf sets on the edge following any cycle with enq_val & !enq_rdy; err_unf likewise for deq_rdy & !deq_val.
  - Both error flags clear only on reset.

Decomposition:
- Shared package seq_fifo_pkg holds:
  - localparams NENTRIES=8, NBITS=8, ADDR_W=3, CNT_W=4;
  - typedef addr_t (logic [2:0]);
  - typedef cnt_t (logic [3:0]).
- One sub-module, seq_ptr_wrap, used twice (head and tail): an ADDR_W-bit register with async active-low reset, an increment enable, and natural wrap.
- Count, flags and handshake logic stay in the top module.

Test Plan:
- Reset, then idle -> enq_rdy=1, deq_val=0, count=0, rf_write_en=0, almost_full=0, both error flags 0.
- Enqueue 0x11..0x88 on 8 back-to-back cycles with deq_rdy=0 -> rf_write_addr runs 0..7; count=8; almost_full=1 once count>=6; enq_rdy=0 after the 8th write.
- From full, hold enq_val=1 and deq_rdy=1 for one cycle -> only the dequeue fires; deq_msg=0x11; count=7; err_ovf=1 on the next cycle.
- Steady stream with enq_val and deq_rdy both held at 1 for 20 cycles, starting from count=2 -> count stays 2; head and tail wrap 7->0; deq_msg order matches enqueue order.
- Empty, enq 0xA5 with deq_rdy=1 -> no dequeue that cycle (deq_val=0); next cycle deq_val=1, deq_msg=0xA5; count returns to 0 after the dequeue.
- Drop reset_n mid-stream with count=5, asynchronously between clock edges -> count=0, deq_val=0 and enq_rdy=1 immediately, without waiting for a clock edge; the next enqueue writes address 0.
